// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter sharing one single-port RAM.
// Requester 0 has priority; requester 1 is forced through after MAX_WAIT denials.
module ram_port_arbiter #(
    parameter int AW       = 12,
    parameter int DW       = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          R0_REQ,
    input  logic [AW-1:0] R0_ADDR,
    input  logic          R0_WREN,
    input  logic [DW-1:0] R0_DATA,
    output logic          R0_GNT,
    output logic [DW-1:0] R0_Q,
    output logic          R0_VALID,
    input  logic          R1_REQ,
    input  logic [AW-1:0] R1_ADDR,
    input  logic          R1_WREN,
    input  logic [DW-1:0] R1_DATA,
    output logic          R1_GNT,
    output logic [DW-1:0] R1_Q,
    output logic          R1_VALID,
    output logic [AW-1:0] RAM_ADDR,
    output logic          RAM_WREN,
    output logic [DW-1:0] RAM_DATA,
    input  logic [DW-1:0] RAM_Q,
    output logic          STARVED
);

    logic [7:0]    wait_cnt;
    logic          at_max;
    logic          gnt0;
    logic          gnt1;
    logic [AW-1:0] held_addr;
    logic [DW-1:0] held_data;
    logic          v0;
    logic          v1;
    logic [DW-1:0] q0;
    logic [DW-1:0] q1;

    assign at_max = (wait_cnt == 8'(MAX_WAIT));

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!RST) begin
            if (R1_REQ && at_max)
                gnt1 = 1'b1;
            else if (R0_REQ)
                gnt0 = 1'b1;
            else if (R1_REQ)
                gnt1 = 1'b1;
        end
    end

    // Idle cycles park the RAM on the last granted address/data.
    always_comb begin
        RAM_ADDR = held_addr;
        RAM_DATA = held_data;
        RAM_WREN = 1'b0;
        if (gnt0) begin
            RAM_ADDR = R0_ADDR;
            RAM_DATA = R0_DATA;
            RAM_WREN = R0_WREN;
        end else if (gnt1) begin
            RAM_ADDR = R1_ADDR;
            RAM_DATA = R1_DATA;
            RAM_WREN = R1_WREN;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wait_cnt  <= '0;
            held_addr <= '0;
            held_data <= '0;
            v0        <= 1'b0;
            v1        <= 1'b0;
            q0        <= '0;
            q1        <= '0;
        end else begin
            if (!R1_REQ || gnt1)
                wait_cnt <= '0;
            else if (!at_max)
                wait_cnt <= wait_cnt + 8'd1;
            if (gnt0 || gnt1) begin
                held_addr <= RAM_ADDR;
                held_data <= RAM_DATA;
            end
            v0 <= gnt0 && !R0_WREN;
            v1 <= gnt1 && !R1_WREN;
            if (gnt0 && !R0_WREN)
                q0 <= RAM_Q;
            if (gnt1 && !R1_WREN)
                q1 <= RAM_Q;
        end
    end

    // Reset masks read-return outputs at once, even for an in-flight read.
    assign R0_GNT   = gnt0;
    assign R1_GNT   = gnt1;
    assign R0_VALID = v0 && !RST;
    assign R1_VALID = v1 && !RST;
    assign R0_Q     = RST ? '0 : q0;
    assign R1_Q     = RST ? '0 : q1;
    assign STARVED  = at_max && !RST;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter with a negedge-clocked RAM model.
// Expected read data is queued at grant time and checked on VALID.
module tb_ram_port_arbiter;

    localparam int AW = 12;
    localparam int DW = 16;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          r0_req, r0_wren, r1_req, r1_wren;
    logic [AW-1:0] r0_addr, r1_addr;
    logic [DW-1:0] r0_data, r1_data;
    logic          r0_gnt, r1_gnt, r0_valid, r1_valid;
    logic [DW-1:0] r0_q, r1_q;
    logic [AW-1:0] ram_addr;
    logic          ram_wren;
    logic [DW-1:0] ram_data;
    logic [DW-1:0] ram_q;
    logic          starved;

    ram_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MW)) dut (
        .CLK(clk), .RST(rst),
        .R0_REQ(r0_req), .R0_ADDR(r0_addr), .R0_WREN(r0_wren),
        .R0_DATA(r0_data), .R0_GNT(r0_gnt), .R0_Q(r0_q),
        .R0_VALID(r0_valid),
        .R1_REQ(r1_req), .R1_ADDR(r1_addr), .R1_WREN(r1_wren),
        .R1_DATA(r1_data), .R1_GNT(r1_gnt), .R1_Q(r1_q),
        .R1_VALID(r1_valid),
        .RAM_ADDR(ram_addr), .RAM_WREN(ram_wren),
        .RAM_DATA(ram_data), .RAM_Q(ram_q), .STARVED(starved)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [4096];
    always @(negedge clk) begin
        ram_q <= mem[ram_addr];
        if (ram_wren)
            mem[ram_addr] = ram_data;
    end

    int            vectors = 0;
    int            miscompares = 0;
    logic [DW-1:0] shadow [4096];
    logic [DW-1:0] q0_exp [$];
    logic [DW-1:0] q1_exp [$];
    logic          pv0 = 1'b0, pv1 = 1'b0;
    logic [DW-1:0] last0 = '0, last1 = '0;
    logic [AW-1:0] held_a = '0;
    logic [DW-1:0] held_d = '0;
    int            mw = 0;
    int            n_r1 = 0, n_st = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        logic          g0, g1, st;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic [DW-1:0] d;
        #1;
        if (pv0) last0 = q0_exp.pop_front();
        if (pv1) last1 = q1_exp.pop_front();
        chk("r0_valid", 32'(r0_valid), 32'(pv0 && !rst));
        chk("r1_valid", 32'(r1_valid), 32'(pv1 && !rst));
        chk("r0_q", 32'(r0_q), rst ? 32'd0 : 32'(last0));
        chk("r1_q", 32'(r1_q), rst ? 32'd0 : 32'(last1));
        st = !rst && (mw == MW);
        g1 = !rst && r1_req && (st || !r0_req);
        g0 = !rst && r0_req && !(r1_req && st);
        chk("r0_gnt", 32'(r0_gnt), 32'(g0));
        chk("r1_gnt", 32'(r1_gnt), 32'(g1));
        chk("starved", 32'(starved), 32'(st));
        ea = g0 ? r0_addr : (g1 ? r1_addr : held_a);
        ed = g0 ? r0_data : (g1 ? r1_data : held_d);
        chk("ram_addr", 32'(ram_addr), 32'(ea));
        chk("ram_data", 32'(ram_data), 32'(ed));
        chk("ram_wren", 32'(ram_wren),
            32'((g0 && r0_wren) || (g1 && r1_wren)));
        if (r1_gnt) n_r1++;
        if (starved) n_st++;
        if (g0) begin
            if (r0_wren) shadow[r0_addr] = r0_data;
            else begin d = shadow[r0_addr]; q0_exp.push_back(d); end
        end
        if (g1) begin
            if (r1_wren) shadow[r1_addr] = r1_data;
            else begin d = shadow[r1_addr]; q1_exp.push_back(d); end
        end
        pv0 = g0 && !r0_wren;
        pv1 = g1 && !r1_wren;
        if (rst) begin
            mw = 0; held_a = '0; held_d = '0; last0 = '0; last1 = '0;
        end else begin
            if (!r1_req || g1) mw = 0;
            else if (mw != MW) mw++;
            if (g0 || g1) begin held_a = ea; held_d = ed; end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic req, input logic [AW-1:0] a,
                          input logic we, input logic [DW-1:0] d);
        r0_req = req; r0_addr = a; r0_wren = we; r0_data = d;
    endtask

    task automatic drive1(input logic req, input logic [AW-1:0] a,
                          input logic we, input logic [DW-1:0] d);
        r1_req = req; r1_addr = a; r1_wren = we; r1_data = d;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem[i] = 16'(i * 16'h0101) ^ 16'h5A5A;
            shadow[i] = mem[i];
        end
        mem[12'h010] = 16'hBEEF;
        shadow[12'h010] = 16'hBEEF;
        rst = 1'b1;
        drive0(1'b1, 12'h100, 1'b0, 16'h0);
        drive1(1'b1, 12'h200, 1'b0, 16'h0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) step();
        rst = 1'b0;
        n_r1 = 0; n_st = 0;
        for (int i = 0; i < 20; i++) step();
        chk("r1_share", 32'(n_r1), 32'd4);
        chk("starved_cnt", 32'(n_st), 32'd4);
        drive0(1'b0, 12'h0, 1'b0, 16'h0);
        drive1(1'b0, 12'h0, 1'b0, 16'h0);
        step();
        drive1(1'b1, 12'h010, 1'b0, 16'h0);
        step();
        drive1(1'b0, 12'h010, 1'b0, 16'h0);
        step();
        chk("beef_read", 32'(last1), 32'hBEEF);
        drive0(1'b1, 12'h7FF, 1'b1, 16'h1234);
        step();
        drive0(1'b1, 12'h7FF, 1'b0, 16'h0);
        step();
        drive0(1'b0, 12'h7FF, 1'b0, 16'h0);
        step();
        chk("raw_read", 32'(last0), 32'h1234);
        drive0(1'b1, 12'h0AB, 1'b0, 16'h0);
        step();
        drive0(1'b0, 12'h0AB, 1'b0, 16'h0);
        for (int i = 0; i < 5; i++) step();
        chk("idle_addr", 32'(ram_addr), 32'h0AB);
        drive1(1'b1, 12'h010, 1'b0, 16'h0);
        step();
        rst = 1'b1;
        drive1(1'b0, 12'h010, 1'b0, 16'h0);
        step();
        rst = 1'b0;
        step();
        for (int i = 0; i < 60; i++) begin
            drive0(1'($urandom_range(0, 1)), 12'($urandom_range(0, 15)),
                   1'($urandom_range(0, 1)), 16'($urandom));
            drive1(1'($urandom_range(0, 1)), 12'($urandom_range(0, 15)),
                   1'($urandom_range(0, 3) == 0), 16'($urandom));
            step();
        end
        drive0(1'b0, 12'h0, 1'b0, 16'h0);
        drive1(1'b0, 12'h0, 1'b0, 16'h0);
        step();
        step();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
